// File: rtl/accum_pio_pkg.sv
// Shared definitions for the accumulator PIO slave: register map, bit indices
// and the accumulator type.
package accum_pio_pkg;

  localparam int unsigned ACC_W = 8;
  typedef logic [ACC_W-1:0] acc_t;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_SWITCH = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  // STATUS bit indices
  localparam int unsigned ST_OVF = 0;
  localparam int unsigned ST_ACC = 1;
  localparam int unsigned ST_CLR = 2;

  // CTRL bit indices
  localparam int unsigned CT_KEYEN = 0;
  localparam int unsigned CT_IRQEN = 1;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer, stability counter and press-pulse generator for one
// active-low push button.
//   clk, reset_n : clock, async active-low reset
//   key_n        : raw asynchronous active-low key
//   level        : debounced key level (1 = released)
//   press        : one-cycle pulse on a debounced 1->0 transition
module key_debouncer
  import accum_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic             meta_q, sync_q, level_q, press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_d, press_d;
  logic [CNT_W-1:0] cnt_d;

  // Count while the synced level disagrees; commit after the full window
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_q != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q;
        press_d = ~sync_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= key_n;
      sync_q  <= meta_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/accum_pio_slave.sv
// Avalon-MM slave wrapping a key-driven 8-bit accumulator.
//   clk, reset_n        : clock, async active-low reset
//   key_accum_n         : raw accumulate key (active-low)
//   key_clear_n         : raw clear key (active-low)
//   sw[7:0]             : raw switches
//   avs_*               : Avalon-MM slave, read latency 1, no waitrequest
//   led[7:0]            : accumulator value
//   irq                 : interrupt; generated only when ACCUM_PIO_IRQ_EN is
//                         defined, otherwise tied 0
module accum_pio_slave
  import accum_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_accum_n,
  input  logic        key_clear_n,
  input  logic [7:0]  sw,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [7:0]  led,
  output logic        irq
);

  logic        acc_press, clr_press;
  logic        acc_level_unused, clr_level_unused, wdata_unused;
  acc_t        sw_meta_q, sw_sync_q;
  acc_t        acc_q, acc_d;
  logic [2:0]  status_q, status_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic [8:0]  sum;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_accum_n),
    .level   (acc_level_unused),
    .press   (acc_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb_clear (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_clear_n),
    .level   (clr_level_unused),
    .press   (clr_press)
  );

  assign wdata_unused = ^avs_writedata[31:8];
  assign sum          = {1'b0, acc_q} + {1'b0, sw_sync_q};

  // Register next-state: bus write beats key action, clear beats add,
  // hardware status set beats W1C
  always_comb begin
    acc_d    = acc_q;
    status_d = status_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;

    if (ctrl_q[CT_KEYEN] && clr_press) begin
      acc_d = '0;
    end else if (ctrl_q[CT_KEYEN] && acc_press) begin
      acc_d = sum[7:0];
    end

    if (avs_write) begin
      case (avs_address)
        ADDR_DATA:   acc_d    = avs_writedata[7:0];
        ADDR_STATUS: status_d = status_q & ~avs_writedata[2:0];
        ADDR_CTRL:   ctrl_d   = avs_writedata[1:0];
        default:     ;
      endcase
    end

    // Overflow only counts when the add actually lands in the accumulator
    if (ctrl_q[CT_KEYEN] && acc_press && !clr_press && sum[8] &&
        !(avs_write && avs_address == ADDR_DATA)) begin
      status_d[ST_OVF] = 1'b1;
    end
    if (acc_press) status_d[ST_ACC] = 1'b1;
    if (clr_press) status_d[ST_CLR] = 1'b1;

    // Reads return the pre-write register contents
    if (avs_read) begin
      case (avs_address)
        ADDR_DATA:   rdata_d = 32'(acc_q);
        ADDR_SWITCH: rdata_d = 32'(sw_sync_q);
        ADDR_STATUS: rdata_d = 32'(status_q);
        default:     rdata_d = 32'(ctrl_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_meta_q <= '1;
      sw_sync_q <= '1;
      acc_q     <= '0;
      status_q  <= '0;
      ctrl_q    <= 2'b01;
      rdata_q   <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      acc_q     <= acc_d;
      status_q  <= status_d;
      ctrl_q    <= ctrl_d;
      rdata_q   <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign led          = acc_q;

`ifdef ACCUM_PIO_IRQ_EN
  logic irq_q;

  // Level interrupt from key-press flags, gated by irq_en
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_q[CT_IRQEN] & (status_q[ST_ACC] | status_q[ST_CLR]);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: doc/accum_pio_slave.md
Name: accum_pio_slave

Overview:
- Avalon-MM slave peripheral that terminates Nios II bus accesses on a hardware accumulator; it is the responder for the processor's bus master.
- Conditions the raw push-buttons and switch bank, adds SW into an 8-bit accumulator on an accumulate press, clears it on a clear press, and drives LEDG.
- Exposes accumulator, switch, status and control registers to software.
- Sits in the FPGA fabric beside the Nios SoC, on an exported Avalon-MM slave conduit.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before a debounced key level changes (10 ms at 50 MHz).
- CNT_W, 19: width of the debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset_n  in  1  asynchronous, active-low reset
- key_accum_n  in  1  raw KEY[3], active-low, asynchronous
- key_clear_n  in  1  raw KEY[2], active-low, asynchronous
- sw  in  8  raw switches, asynchronous
- avs_address  in  2  register word index
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, fixed read latency 1
- led  out  8  accumulator value to LEDG
- irq  out  1  interrupt; present only with the macro, otherwise tied 0

Behaviour:
- Reset is asynchronous and active-low, applied on reset_n low.
  - Reset values: led=0, avs_readdata=0, irq=0, accumulator=0, STATUS=0, CTRL=0x1.
  - Sync flops reset to 1 (released); debounced levels reset to 1; counters reset to 0.
- Synchronizers: 2-FF on key_accum_n, key_clear_n and each sw bit.
- Debounce, per key:
  - The counter increments while the synced level differs from the debounced level; it is zeroed on any cycle they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced level and the counter is zeroed.
- Press event: a one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
- Event latency: a stable pin edge produces a pulse 2+DEBOUNCE_CYCLES cycles later; the accumulator updates the following cycle.
- Register map (32-bit, unused bits read 0):
  - 0 DATA, RW: [7:0] accumulator; a write loads writedata[7:0].
  - 1 SWITCH, RO: [7:0] synchronized sw; writes ignored.
  - 2 STATUS, W1C: [0] overflow sticky, [1] accum-press seen, [2] clear-press seen.
  - 3 CTRL, RW: [0] key_en, [1] irq_en (stored regardless of macro).
- Accumulate press with key_en=1: acc <= acc + sw_sync, mod 256. A carry out sets STATUS[0]. STATUS[1] is set regardless of key_en.
- Clear press with key_en=1: acc <= 0; STATUS[0] unchanged. STATUS[2] is set regardless of key_en.
- Simultaneous events and priority:
  - Clear and accumulate pulses in the same cycle: clear wins and no add occurs; both STATUS flags are set.
  - Bus write to DATA in the same cycle as a key action: the bus write wins; STATUS flags are still set.
  - W1C in the same cycle as a hardware set of the same bit: the set wins.
- Read:
  - avs_readdata is registered, valid the cycle after avs_read; no waitrequest.
  - It holds its value when no read is issued.
  - Read and write in the same cycle: the write is performed and readdata returns the pre-write value.
- led = acc, registered, so it equals DATA at all times.
- Reset mid-debounce discards partial counts; a still-held key must re-qualify for the full DEBOUNCE_CYCLES.

Optional Feature:
- Macro: ACCUM_PIO_IRQ_EN.
- Defined: irq = CTRL[1] & (STATUS[1] | STATUS[2]), registered, so it asserts the cycle after the flag sets. It deasserts the cycle after software clears the flags or clears irq_en.
- Undefined: irq is constant 0 and no interrupt logic is generated. CTRL[1] remains a plain RW bit.

Decomposition:
- Package accum_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_SWITCH=1, ADDR_STATUS=2, ADDR_CTRL=3;
  - STATUS bit indices ST_OVF, ST_ACC, ST_CLR;
  - CTRL bit indices CT_KEYEN, CT_IRQEN;
  - typedef acc_t as logic [7:0].
- One sub-module, key_debouncer, instantiated twice. It contains the 2-FF sync, counter and falling-edge pulse (ports clk, reset_n, key_n, level, press).

Test Plan (DEBOUNCE_CYCLES=4 throughout):
1. Reset then read all four registers -> DATA=0, SWITCH=sw, STATUS=0, CTRL=0x1; led=0, irq=0.
2. sw=0x05, hold key_accum_n low 20 cycles, twice (released between) -> led=0x0A, STATUS=0x2. A 3-cycle glitch low produces no change.
3. DATA written 0xF0, sw=0x20, one accumulate press -> led=0x10, STATUS[0]=1. Write STATUS 0x1 -> STATUS[0]=0.
4. Both keys pressed in the same cycle with acc=0x33 -> acc=0x00, STATUS=0x6. With CTRL=0 a press leaves acc unchanged and still sets the flag.
5. Bus write DATA=0x77 in the same cycle as an accumulate pulse -> DATA=0x77. Read issued together with that write returns the old value.
6. ACCUM_PIO_IRQ_EN defined, CTRL=0x3, clear press -> irq=1 the cycle after STATUS[2] sets. Write STATUS 0x4 -> irq=0 next cycle. Macro undefined -> irq stays 0.
